// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : datapath_seq
// Purpose  : Micro-instruction sequencer driving the MxN datapath controls
//            (load / shift / write-back). Optional: DATAPATH_SEQ_R0_PROTECT_EN
// Revision : 1.0 - initial release
// ============================================================================
module datapath_seq #(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int P  = 3,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [P-1:0]  instr_dst,
    input  logic [P-1:0]  instr_srca,
    input  logic [P-1:0]  instr_srcb,
    input  logic [1:0]    instr_alu,
    input  logic          instr_shdir,
    input  logic [CW-1:0] instr_shcnt,
    input  logic          instr_nowb,
    input  logic          fov,
    input  logic          fcarry,
    input  logic          fneg,
    input  logic          fzero,
    output logic [P-1:0]  selection_multa,
    output logic [P-1:0]  selection_multb,
    output logic [1:0]    selection_alu,
    output logic [1:0]    selection_sr,
    output logic [N-1:0]  writer,
    output logic [3:0]    flags_q,
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
    output logic          wp_err,
`endif
    output logic          done,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0] SR_LOAD  = 2'b00;
    localparam logic [1:0] SR_LEFT  = 2'b01;
    localparam logic [1:0] SR_RIGHT = 2'b10;
    localparam logic [1:0] SR_HOLD  = 2'b11;

    if (((2 ** P) < N) || (M < 1)) begin : g_param_check
        $error("datapath_seq: register index width P too small for N, or M < 1");
    end

    state_t          state_q, state_d;
    logic [P-1:0]    dst_q, dst_d;
    logic [P-1:0]    srca_q, srca_d;
    logic [P-1:0]    srcb_q, srcb_d;
    logic [1:0]      alu_q, alu_d;
    logic            shdir_q, shdir_d;
    logic            nowb_q, nowb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      flags_d;
    logic            wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dst_q   <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            alu_q   <= '0;
            shdir_q <= 1'b0;
            nowb_q  <= 1'b0;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            alu_q   <= alu_d;
            shdir_q <= shdir_d;
            nowb_q  <= nowb_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    // Out-of-range and suppressed destinations never assert a write enable.
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
    assign wr_en = !nowb_q && (int'(dst_q) < N) && (dst_q != '0);
`else
    assign wr_en = !nowb_q && (int'(dst_q) < N);
`endif

    always_comb begin
        state_d      = state_q;
        dst_d        = dst_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        alu_d        = alu_q;
        shdir_d      = shdir_q;
        nowb_d       = nowb_q;
        cnt_d        = cnt_q;
        flags_d      = flags_q;
        selection_sr = SR_HOLD;
        writer       = '0;
        done         = 1'b0;
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
        wp_err       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    dst_d   = instr_dst;
                    srca_d  = instr_srca;
                    srcb_d  = instr_srcb;
                    alu_d   = instr_alu;
                    shdir_d = instr_shdir;
                    nowb_d  = instr_nowb;
                    cnt_d   = instr_shcnt;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                selection_sr = SR_LOAD;
                flags_d      = {fov, fcarry, fneg, fzero};
                state_d      = (cnt_q != '0) ? SHIFT : WRITE;
            end
            SHIFT: begin
                selection_sr = shdir_q ? SR_RIGHT : SR_LEFT;
                cnt_d        = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                done    = 1'b1;
                writer  = wr_en ? (N'(1) << dst_q) : '0;
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
                wp_err  = !nowb_q && (dst_q == '0);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_ready     = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign selection_multa = srca_q;
    assign selection_multb = srcb_q;
    assign selection_alu   = alu_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_seq
// Purpose  : Directed self-checking bench for datapath_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_seq;

    localparam int N  = 8;
    localparam int M  = 8;
    localparam int P  = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [P-1:0]  instr_dst, instr_srca, instr_srcb;
    logic [1:0]    instr_alu;
    logic          instr_shdir;
    logic [CW-1:0] instr_shcnt;
    logic          instr_nowb;
    logic          fov, fcarry, fneg, fzero;
    logic [P-1:0]  selection_multa, selection_multb;
    logic [1:0]    selection_alu, selection_sr;
    logic [N-1:0]  writer;
    logic [3:0]    flags_q;
    logic          done, busy;
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
    logic          wp_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    datapath_seq #(.N(N), .M(M), .P(P), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_dst       (instr_dst),
        .instr_srca      (instr_srca),
        .instr_srcb      (instr_srcb),
        .instr_alu       (instr_alu),
        .instr_shdir     (instr_shdir),
        .instr_shcnt     (instr_shcnt),
        .instr_nowb      (instr_nowb),
        .fov             (fov),
        .fcarry          (fcarry),
        .fneg            (fneg),
        .fzero           (fzero),
        .selection_multa (selection_multa),
        .selection_multb (selection_multb),
        .selection_alu   (selection_alu),
        .selection_sr    (selection_sr),
        .writer          (writer),
        .flags_q         (flags_q),
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
        .wp_err          (wp_err),
`endif
        .done            (done),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [P-1:0] dst, input logic [P-1:0] sa,
                             input logic [P-1:0] sb, input logic [1:0] alu,
                             input logic dir, input logic [CW-1:0] cnt, input logic nowb);
        instr_dst   = dst;
        instr_srca  = sa;
        instr_srcb  = sb;
        instr_alu   = alu;
        instr_shdir = dir;
        instr_shcnt = cnt;
        instr_nowb  = nowb;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {fov, fcarry, fneg, fzero} = f;
    endtask

    initial begin
        rst         = 1'b0;
        instr_valid = 1'b0;
        set_instr('0, '0, '0, '0, 1'b0, '0, 1'b0);
        set_flags(4'b0000);
        tick();
        tick();
        check("rst_writer", 32'(writer), 32'h0);
        check("rst_sr",     32'(selection_sr), 32'h3);
        check("rst_flags",  32'(flags_q), 32'h0);
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_done",   32'(done), 32'h0);
        check("rst_multa",  32'(selection_multa), 32'h0);
        rst = 1'b1;
        tick();
        check("rel_ready",  32'(instr_ready), 32'h1);

        // dst=3, srca=1, srcb=2, shcnt=0
        set_instr(3'd3, 3'd1, 3'd2, 2'b00, 1'b0, 3'd0, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        set_flags(4'b1010);
        check("t1_load_multa", 32'(selection_multa), 32'd1);
        check("t1_load_multb", 32'(selection_multb), 32'd2);
        check("t1_load_sr",    32'(selection_sr), 32'h0);
        check("t1_load_ready", 32'(instr_ready), 32'h0);
        check("t1_load_busy",  32'(busy), 32'h1);
        check("t1_load_wr",    32'(writer), 32'h0);
        tick();
        set_flags(4'b0000);
        check("t1_wr_writer",  32'(writer), 32'h08);
        check("t1_wr_done",    32'(done), 32'h1);
        check("t1_wr_sr",      32'(selection_sr), 32'h3);
        check("t1_wr_flags",   32'(flags_q), 32'hA);
        tick();
        check("t1_idle_wr",    32'(writer), 32'h0);
        check("t1_idle_done",  32'(done), 32'h0);
        check("t1_idle_busy",  32'(busy), 32'h0);
        check("t1_idle_ready", 32'(instr_ready), 32'h1);
        check("t1_flags_hold", 32'(flags_q), 32'hA);

        // dst=5, shift right 5 times
        set_instr(3'd5, 3'd4, 3'd7, 2'b10, 1'b1, 3'd5, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("t2_load_sr",   32'(selection_sr), 32'h0);
        check("t2_load_alu",  32'(selection_alu), 32'h2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_shift_sr",    32'(selection_sr), 32'h2);
            check("t2_shift_wr",    32'(writer), 32'h0);
            check("t2_shift_multb", 32'(selection_multb), 32'd7);
            check("t2_shift_ready", 32'(instr_ready), 32'h0);
        end
        tick();
        check("t2_wr_writer", 32'(writer), 32'h20);
        check("t2_wr_done",   32'(done), 32'h1);
        check("t2_flags",     32'(flags_q), 32'h0);
        tick();
        check("t2_idle_ready", 32'(instr_ready), 32'h1);

        // nowb with fzero during LOAD
        set_instr(3'd6, 3'd2, 3'd3, 2'b01, 1'b0, 3'd0, 1'b1);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        set_flags(4'b0001);
        tick();
        set_flags(4'b0000);
        check("t3_wr_writer", 32'(writer), 32'h0);
        check("t3_wr_done",   32'(done), 32'h1);
        check("t3_flags",     32'(flags_q), 32'h1);
        tick();

        // two back-to-back instructions with valid held high
        set_instr(3'd2, 3'd5, 3'd6, 2'b11, 1'b0, 3'd1, 1'b0);
        instr_valid = 1'b1;
        tick();
        set_instr(3'd4, 3'd3, 3'd1, 2'b00, 1'b0, 3'd0, 1'b0);
        check("t4_a_load_ready", 32'(instr_ready), 32'h0);
        check("t4_a_load_multa", 32'(selection_multa), 32'd5);
        tick();
        check("t4_a_shift_sr",    32'(selection_sr), 32'h1);
        check("t4_a_shift_ready", 32'(instr_ready), 32'h0);
        tick();
        check("t4_a_wr_writer", 32'(writer), 32'h04);
        check("t4_a_wr_ready",  32'(instr_ready), 32'h0);
        tick();
        check("t4_idle_ready",  32'(instr_ready), 32'h1);
        check("t4_idle_busy",   32'(busy), 32'h0);
        tick();
        instr_valid = 1'b0;
        check("t4_b_load_multa", 32'(selection_multa), 32'd3);
        check("t4_b_load_sr",    32'(selection_sr), 32'h0);
        tick();
        check("t4_b_wr_writer", 32'(writer), 32'h10);
        tick();

        // dst = 0
        set_instr(3'd0, 3'd1, 3'd1, 2'b00, 1'b0, 3'd0, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("t5_done", 32'(done), 32'h1);
`ifdef DATAPATH_SEQ_R0_PROTECT_EN
        check("t5_writer_prot", 32'(writer), 32'h0);
        check("t5_wp_err",      32'(wp_err), 32'h1);
`else
        check("t5_writer", 32'(writer), 32'h01);
`endif
        tick();

        // reset mid-instruction
        set_instr(3'd7, 3'd2, 3'd2, 2'b01, 1'b0, 3'd7, 1'b0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        set_flags(4'b1111);
        tick();
        set_flags(4'b0000);
        check("t6_flags_pre", 32'(flags_q), 32'hF);
        tick();
        rst = 1'b0;
        #1;
        check("t6_rst_writer", 32'(writer), 32'h0);
        check("t6_rst_sr",     32'(selection_sr), 32'h3);
        check("t6_rst_flags",  32'(flags_q), 32'h0);
        check("t6_rst_busy",   32'(busy), 32'h0);
        check("t6_rst_done",   32'(done), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("t6_rel_ready", 32'(instr_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_no_write", 32'({done, writer}), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
